sha1_block_ctrl: RTL and testbench
==================================

Name: sha1_block_ctrl

Overview:
Top-level sequencer for one 512-bit SHA-1 block in the hashing module. It drives the shared message/round index counter through four phases: message word load (t=0..15), schedule extension (t=16..79), compression rounds (t=0..79) and the digest update. It emits the enables that steer the W buffer, the round datapath and the H registers, with a valid/ready handshake on message input and a start/done handshake to the host.

Parameters:
NUM_ROUNDS, 80, total schedule words and compression rounds.
BLOCK_WORDS, 16, 32-bit words loaded per block.
CNT_W, 8, width of the index counter t.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  begin a block; accepted only in IDLE.
first_block  in  1  sampled with start; 1 loads the SHA-1 IV into H.
abort  in  1  synchronous cancel; highest priority after reset.
word_valid  in  1  message word present on the W input bus.
word_ready  out  1  controller accepts a word this cycle.
w_load_en  out  1  write input word into W[w_idx].
ext_en  out  1  compute W[w_idx] from the schedule recurrence.
round_en  out  1  execute compression round w_idx.
w_idx  out  CNT_W  current t.
round_phase  out  2  K/f selector: t/20 during ROUND, else 0.
h_init  out  1  load IV into H.
var_init  out  1  load a..e from H.
h_update  out  1  H += a..e.
busy  out  1  block in progress.
done  out  1  one-cycle completion pulse.

Behaviour:
- Decided: one clock `clk`. Reset `rst_n` is asynchronous and active-low.
- States: IDLE, LOAD, EXT, ROUND, UPDATE, DONE. On reset: state IDLE, t=0, every output 0.
- IDLE: `start`=1 moves to LOAD with t<=0. `h_init` = `start` & `first_block`, combinational, in that same cycle.
- LOAD:
  - `word_ready`=1.
  - `w_load_en` = `word_valid` & `word_ready`, combinational.
  - A handshake increments t.
  - `word_valid`=0 stalls: t holds and no enables are asserted.
  - A handshake at t=15 moves to EXT with t<=16.
- EXT: `ext_en`=1 every cycle while t runs 16..79. `var_init`=1 only in the t=79 cycle. At t=79 move to ROUND with t<=0.
- ROUND: `round_en`=1 while t runs 0..79. `round_phase` = 0 for t 0-19, 1 for 20-39, 2 for 40-59, 3 for 60-79. At t=79 move to UPDATE.
- UPDATE: `h_update`=1 for one cycle, then DONE.
- DONE: `done`=1 for one cycle, then IDLE with t<=0.
- `busy`=1 in LOAD, EXT, ROUND and UPDATE; 0 in IDLE and DONE.
- `w_idx` always equals t. All enables are mutually exclusive.
- `start` outside IDLE is ignored. `word_valid` outside LOAD is ignored, and `word_ready` is 0 there.
- Latency with `word_valid` held high: `start` at cycle 0, LOAD 1-16, EXT 17-80, ROUND 81-160, UPDATE 161, `done` at 162. Every LOAD stall cycle adds one cycle.
- `abort`=1 in any non-IDLE state: next cycle IDLE, t=0, no `h_update`, no `done`. `abort` in IDLE has no effect. `abort` and `start` together in IDLE: `abort` wins, `start` is ignored.
- `rst_n` low mid-block: immediate return to IDLE with all outputs 0. H contents are undefined and the host must restart with `first_block`=1.
- t never exceeds 79 and never wraps through 255. Transitions compare t against NUM_ROUNDS-1 and BLOCK_WORDS-1.

Test Plan:
- Reset, then `start`=1 with `first_block`=1 and `word_valid` high throughout -> `h_init` in cycle 0; 16 `w_load_en` pulses with `w_idx` 0..15; 64 `ext_en` with `w_idx` 16..79; `var_init` at `w_idx`=79; 80 `round_en`; `h_update` at cycle 161; `done` at cycle 162; `busy` low at 162.
- `word_valid` low for 3 cycles at t=5 -> `w_idx` holds at 5, no `w_load_en` during the stall, `done` moves to cycle 165.
- Check `round_phase` during ROUND -> 0 at t=19, 1 at t=20, 2 at t=40, 3 at t=79; 0 during EXT.
- `start` pulsed during ROUND at t=30 -> ignored, sequence unchanged. Second block with `first_block`=0 -> no `h_init`.
- `abort` at EXT t=40 -> IDLE next cycle, `w_idx`=0, no `h_update` or `done`. A following `start` runs a full 162-cycle block.
- `rst_n` asserted at ROUND t=50 -> all outputs 0 immediately, state IDLE after release, `word_ready`=0.

Source files
------------

// File: rtl/sha1_block_ctrl.sv
// Block-level sequencer for SHA-1: walks the shared index t through message load,
// schedule extension, 80 compression rounds and the final H update.
module sha1_block_ctrl #(
    parameter int NUM_ROUNDS  = 80,
    parameter int BLOCK_WORDS = 16,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             first_block,
    input  logic             abort,
    input  logic             word_valid,
    output logic             word_ready,
    output logic             w_load_en,
    output logic             ext_en,
    output logic             round_en,
    output logic [CNT_W-1:0] w_idx,
    output logic [1:0]       round_phase,
    output logic             h_init,
    output logic             var_init,
    output logic             h_update,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EXT,
        S_ROUND,
        S_UPDATE,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] T_LAST_WORD = CNT_W'(BLOCK_WORDS - 1);
    localparam logic [CNT_W-1:0] T_LAST      = CNT_W'(NUM_ROUNDS - 1);
    localparam logic [CNT_W-1:0] T_PHASE1    = CNT_W'(NUM_ROUNDS / 4);
    localparam logic [CNT_W-1:0] T_PHASE2    = CNT_W'(NUM_ROUNDS / 2);
    localparam logic [CNT_W-1:0] T_PHASE3    = CNT_W'((3 * NUM_ROUNDS) / 4);

    // SHA-1 switches f/K every quarter of the rounds.
    function automatic logic [1:0] phase_of(input logic [CNT_W-1:0] t);
        if (t < T_PHASE1) begin
            return 2'd0;
        end else if (t < T_PHASE2) begin
            return 2'd1;
        end else if (t < T_PHASE3) begin
            return 2'd2;
        end
        return 2'd3;
    endfunction

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] t_q;
    logic [CNT_W-1:0] t_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            t_q     <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
        end
    end

    assign w_idx = t_q;

    always_comb begin
        state_d     = state_q;
        t_d         = t_q;
        word_ready  = 1'b0;
        w_load_en   = 1'b0;
        ext_en      = 1'b0;
        round_en    = 1'b0;
        round_phase = 2'd0;
        h_init      = 1'b0;
        var_init    = 1'b0;
        h_update    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        case (state_q)
            S_IDLE: begin
                // abort in IDLE only suppresses a coincident start
                if (start && !abort) begin
                    state_d = S_LOAD;
                    t_d     = '0;
                    h_init  = first_block & rst_n;
                end
            end
            S_LOAD: begin
                busy       = 1'b1;
                word_ready = 1'b1;
                w_load_en  = word_valid;
                if (word_valid) begin
                    t_d = t_q + CNT_W'(1);
                    if (t_q == T_LAST_WORD) begin
                        state_d = S_EXT;
                    end
                end
            end
            S_EXT: begin
                busy     = 1'b1;
                ext_en   = 1'b1;
                // a..e load from H alongside the last schedule word
                var_init = (t_q == T_LAST);
                if (t_q == T_LAST) begin
                    state_d = S_ROUND;
                    t_d     = '0;
                end else begin
                    t_d = t_q + CNT_W'(1);
                end
            end
            S_ROUND: begin
                busy        = 1'b1;
                round_en    = 1'b1;
                round_phase = phase_of(t_q);
                if (t_q == T_LAST) begin
                    state_d = S_UPDATE;
                end else begin
                    t_d = t_q + CNT_W'(1);
                end
            end
            S_UPDATE: begin
                busy     = 1'b1;
                h_update = 1'b1;
                state_d  = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
                t_d     = '0;
            end
            default: begin
                state_d = S_IDLE;
                t_d     = '0;
            end
        endcase

        // Abort cancels the cycle's side effects so no word, H update or done leaks out.
        if (abort && state_q != S_IDLE) begin
            state_d     = S_IDLE;
            t_d         = '0;
            word_ready  = 1'b0;
            w_load_en   = 1'b0;
            ext_en      = 1'b0;
            round_en    = 1'b0;
            round_phase = 2'd0;
            var_init    = 1'b0;
            h_update    = 1'b0;
            done        = 1'b0;
        end
    end

endmodule

// File: tb/tb_sha1_block_ctrl.sv
// Bench for sha1_block_ctrl: per-cycle output trace compared against an expected
// trace built phase by phase from the block schedule.
module tb_sha1_block_ctrl;

    localparam int MAXC = 400;

    typedef struct packed {
        logic       wr;
        logic       wl;
        logic       ex;
        logic       rn;
        logic       hi;
        logic       vi;
        logic       hu;
        logic       bz;
        logic       dn;
        logic [1:0] ph;
        logic [7:0] idx;
    } obs_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       first_block;
    logic       abort;
    logic       word_valid;
    logic       word_ready;
    logic       w_load_en;
    logic       ext_en;
    logic       round_en;
    logic [7:0] w_idx;
    logic [1:0] round_phase;
    logic       h_init;
    logic       var_init;
    logic       h_update;
    logic       busy;
    logic       done;

    int   checks;
    int   errors;
    bit   wv_plan [MAXC];
    obs_t obs_q[$];
    obs_t exp_q[$];
    obs_t msk_q[$];

    sha1_block_ctrl #(.NUM_ROUNDS(80), .BLOCK_WORDS(16), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .first_block(first_block),
        .abort(abort), .word_valid(word_valid), .word_ready(word_ready),
        .w_load_en(w_load_en), .ext_en(ext_en), .round_en(round_en),
        .w_idx(w_idx), .round_phase(round_phase), .h_init(h_init),
        .var_init(var_init), .h_update(h_update), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t sample();
        obs_t o;
        o.wr = word_ready; o.wl = w_load_en; o.ex = ext_en; o.rn = round_en;
        o.hi = h_init; o.vi = var_init; o.hu = h_update; o.bz = busy; o.dn = done;
        o.ph = round_phase; o.idx = w_idx;
        return o;
    endfunction

    function automatic obs_t ent(input bit wr, wl, ex, rn, hi, vi, hu, bz, dn,
                                 input int ph, input int idx);
        obs_t o;
        o.wr = wr; o.wl = wl; o.ex = ex; o.rn = rn; o.hi = hi; o.vi = vi;
        o.hu = hu; o.bz = bz; o.dn = dn; o.ph = 2'(ph); o.idx = 8'(idx);
        return o;
    endfunction

    // Expected trace: start cycle, 16 accepted words (stalls where word_valid is low),
    // 64 schedule words, 80 rounds in four 20-round phases, update, done, then idle.
    task automatic build_expected(input bit fb, input int n);
        obs_t all_m;
        obs_t noidx_m;
        int   c;
        all_m   = '1;
        noidx_m = '1;
        noidx_m.idx = '0;
        exp_q.delete();
        msk_q.delete();
        exp_q.push_back(ent(0,0,0,0,fb,0,0,0,0,0,0)); msk_q.push_back(all_m);
        c = 1;
        for (int k = 0; k < 16; k++) begin
            while (c < MAXC && !wv_plan[c]) begin
                exp_q.push_back(ent(1,0,0,0,0,0,0,1,0,0,k)); msk_q.push_back(all_m);
                c++;
            end
            exp_q.push_back(ent(1,1,0,0,0,0,0,1,0,0,k)); msk_q.push_back(all_m);
            c++;
        end
        for (int t = 16; t < 80; t++) begin
            exp_q.push_back(ent(0,0,1,0,0,(t == 79),0,1,0,0,t)); msk_q.push_back(all_m);
        end
        for (int t = 0; t < 80; t++) begin
            exp_q.push_back(ent(0,0,0,1,0,0,0,1,0,t / 20,t)); msk_q.push_back(all_m);
        end
        exp_q.push_back(ent(0,0,0,0,0,0,1,1,0,0,0)); msk_q.push_back(noidx_m);
        exp_q.push_back(ent(0,0,0,0,0,0,0,0,1,0,0)); msk_q.push_back(noidx_m);
        while (exp_q.size() < n) begin
            exp_q.push_back('0); msk_q.push_back(all_m);
        end
    endtask

    task automatic set_idle_from(input int c0, input int n);
        for (int c = c0; c < n; c++) begin
            exp_q[c] = '0;
            msk_q[c] = '1;
        end
    endtask

    task automatic wv_all_high();
        for (int c = 0; c < MAXC; c++) wv_plan[c] = 1'b1;
    endtask

    task automatic drive_block(input int n, input int start_c, input bit fb,
                               input int glitch_c, input int abort_c);
        obs_q.delete();
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            start       = (c == start_c) || (c == glitch_c);
            first_block = (c == start_c) ? fb : 1'($urandom);
            abort       = (c == abort_c);
            word_valid  = wv_plan[c];
            @(negedge clk);
            obs_q.push_back(sample());
        end
        @(posedge clk);
        #1;
        start = 1'b0; abort = 1'b0; word_valid = 1'b0; first_block = 1'b0;
    endtask

    task automatic test_reset();
        obs_t o;
        rst_n = 1'b0; start = 1'b0; first_block = 1'b0; abort = 1'b0; word_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        o = sample();
        checks++;
        if (o !== obs_t'('0)) begin
            errors++; $display("FAIL reset_outputs got=%h exp=0", o);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        o = sample();
        checks++;
        if (o !== obs_t'('0)) begin
            errors++; $display("FAIL idle_after_reset got=%h exp=0", o);
        end
        word_valid = 1'b0;
    endtask

    task automatic test_full_block();
        int nl, ne, nr;
        wv_all_high();
        build_expected(1'b1, 166);
        drive_block(166, 0, 1'b1, -1, -1);
        for (int c = 0; c < 166; c++) begin
            checks++;
            if ((obs_q[c] & msk_q[c]) !== (exp_q[c] & msk_q[c])) begin
                errors++; $display("FAIL full cyc=%0d got=%h exp=%h", c, obs_q[c], exp_q[c]);
            end
        end
        nl = 0; ne = 0; nr = 0;
        foreach (obs_q[c]) begin
            nl += int'(obs_q[c].wl); ne += int'(obs_q[c].ex); nr += int'(obs_q[c].rn);
        end
        checks++;
        if (nl !== 16 || ne !== 64 || nr !== 80) begin
            errors++; $display("FAIL enable_counts got=%0d/%0d/%0d exp=16/64/80", nl, ne, nr);
        end
        checks++;
        if (obs_q[161].hu !== 1'b1 || obs_q[162].dn !== 1'b1 || obs_q[162].bz !== 1'b0) begin
            errors++;
            $display("FAIL latency hu161=%b dn162=%b bz162=%b exp=1,1,0",
                     obs_q[161].hu, obs_q[162].dn, obs_q[162].bz);
        end
    endtask

    task automatic test_stall();
        wv_all_high();
        for (int c = 6; c < 9; c++) wv_plan[c] = 1'b0;
        build_expected(1'b1, 169);
        drive_block(169, 0, 1'b1, -1, -1);
        for (int c = 0; c < 169; c++) begin
            checks++;
            if ((obs_q[c] & msk_q[c]) !== (exp_q[c] & msk_q[c])) begin
                errors++; $display("FAIL stall cyc=%0d got=%h exp=%h", c, obs_q[c], exp_q[c]);
            end
        end
        checks++;
        if (obs_q[165].dn !== 1'b1 || obs_q[7].idx !== 8'd5 || obs_q[7].wl !== 1'b0) begin
            errors++;
            $display("FAIL stall_timing dn165=%b idx7=%0d wl7=%b exp=1,5,0",
                     obs_q[165].dn, obs_q[7].idx, obs_q[7].wl);
        end
    endtask

    task automatic test_round_phase();
        wv_all_high();
        drive_block(164, 0, 1'b0, -1, -1);
        checks++;
        if (obs_q[100].ph !== 2'd0 || obs_q[100].idx !== 8'd19) begin
            errors++; $display("FAIL phase_t19 got=%0d idx=%0d exp=0", obs_q[100].ph, obs_q[100].idx);
        end
        checks++;
        if (obs_q[101].ph !== 2'd1) begin
            errors++; $display("FAIL phase_t20 got=%0d exp=1", obs_q[101].ph);
        end
        checks++;
        if (obs_q[121].ph !== 2'd2) begin
            errors++; $display("FAIL phase_t40 got=%0d exp=2", obs_q[121].ph);
        end
        checks++;
        if (obs_q[160].ph !== 2'd3 || obs_q[160].idx !== 8'd79) begin
            errors++; $display("FAIL phase_t79 got=%0d idx=%0d exp=3", obs_q[160].ph, obs_q[160].idx);
        end
        checks++;
        if (obs_q[50].ph !== 2'd0 || obs_q[50].ex !== 1'b1) begin
            errors++; $display("FAIL phase_ext got=%0d ex=%b exp=0,1", obs_q[50].ph, obs_q[50].ex);
        end
    endtask

    task automatic test_start_ignored();
        wv_all_high();
        build_expected(1'b0, 166);
        drive_block(166, 0, 1'b0, 111, -1);
        for (int c = 0; c < 166; c++) begin
            checks++;
            if ((obs_q[c] & msk_q[c]) !== (exp_q[c] & msk_q[c])) begin
                errors++; $display("FAIL start_glitch cyc=%0d got=%h exp=%h", c, obs_q[c], exp_q[c]);
            end
        end
    endtask

    task automatic test_abort();
        obs_t bz_idx_m;
        bz_idx_m     = '0;
        bz_idx_m.bz  = 1'b1;
        bz_idx_m.idx = '1;
        wv_all_high();
        build_expected(1'b1, 80);
        msk_q[41] = bz_idx_m;
        set_idle_from(42, 80);
        drive_block(80, 0, 1'b1, -1, 41);
        for (int c = 0; c < 80; c++) begin
            checks++;
            if ((obs_q[c] & msk_q[c]) !== (exp_q[c] & msk_q[c])) begin
                errors++; $display("FAIL abort cyc=%0d got=%h exp=%h", c, obs_q[c], exp_q[c]);
            end
        end
        build_expected(1'b1, 166);
        drive_block(166, 0, 1'b1, -1, -1);
        for (int c = 0; c < 166; c++) begin
            checks++;
            if ((obs_q[c] & msk_q[c]) !== (exp_q[c] & msk_q[c])) begin
                errors++; $display("FAIL after_abort cyc=%0d got=%h exp=%h", c, obs_q[c], exp_q[c]);
            end
        end
    endtask

    task automatic test_abort_idle();
        wv_all_high();
        build_expected(1'b0, 6);
        set_idle_from(0, 6);
        drive_block(6, 0, 1'b1, -1, 0);
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (obs_q[c] !== exp_q[c]) begin
                errors++; $display("FAIL abort_start_idle cyc=%0d got=%h exp=%h", c, obs_q[c], exp_q[c]);
            end
        end
    endtask

    task automatic test_random_stalls();
        bit fb;
        int nl;
        for (int it = 0; it < 3; it++) begin
            wv_all_high();
            for (int c = 0; c < 40; c++) wv_plan[c] = ($urandom_range(3, 0) != 0);
            fb = 1'($urandom);
            build_expected(fb, 210);
            drive_block(210, 0, fb, -1, -1);
            nl = 0;
            for (int c = 0; c < 210; c++) begin
                nl += int'(obs_q[c].wl);
                checks++;
                if ((obs_q[c] & msk_q[c]) !== (exp_q[c] & msk_q[c])) begin
                    errors++;
                    $display("FAIL rand_stall it=%0d cyc=%0d got=%h exp=%h", it, c, obs_q[c], exp_q[c]);
                end
            end
            checks++;
            if (nl !== 16) begin
                errors++; $display("FAIL rand_load_count it=%0d got=%0d exp=16", it, nl);
            end
        end
    endtask

    task automatic test_reset_mid_block();
        obs_t o;
        wv_all_high();
        drive_block(132, 0, 1'b1, -1, -1);
        checks++;
        if (obs_q[131].rn !== 1'b1 || obs_q[131].idx !== 8'd50) begin
            errors++; $display("FAIL pre_reset got rn=%b idx=%0d exp=1,50", obs_q[131].rn, obs_q[131].idx);
        end
        word_valid = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 o = sample();
        checks++;
        if (o !== obs_t'('0)) begin
            errors++; $display("FAIL async_reset got=%h exp=0", o);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        o = sample();
        checks++;
        if (o !== obs_t'('0)) begin
            errors++; $display("FAIL idle_after_mid_reset got=%h exp=0", o);
        end
        word_valid = 1'b0;
        wv_all_high();
        build_expected(1'b1, 166);
        drive_block(166, 0, 1'b1, -1, -1);
        for (int c = 0; c < 166; c++) begin
            checks++;
            if ((obs_q[c] & msk_q[c]) !== (exp_q[c] & msk_q[c])) begin
                errors++; $display("FAIL restart cyc=%0d got=%h exp=%h", c, obs_q[c], exp_q[c]);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_full_block();
        test_stall();
        test_round_phase();
        test_start_ignored();
        test_abort();
        test_abort_idle();
        test_random_stalls();
        test_reset_mid_block();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
